div_seq: RTL and testbench
==========================

# div_seq

Sequential restoring divider: the inverse of the adder-multiplier datapath. It takes an 18-bit product and a 9-bit sum, and recovers the other 9-bit factor as quotient and remainder, one quotient bit per clock. It sits beside the multiply path, so a product `Y = (A+B)*(C+D)` can be checked or decomposed back into `(C+D)` given `(A+B)`. The handshake is start/busy/valid, with one operation in flight at a time.

## Interface
Parameters:
- `DIVIDEND_W`, default 18: dividend and quotient width.
- `DIVISOR_W`, default 9: divisor and remainder width.

Ports:
- `sys_clk`  in  1: system clock, rising edge.
- `sys_rst_n`  in  1: reset, asynchronous, active-low.
- `div_start`  in  1: request; sampled only while idle.
- `div_in_dividend`  in  DIVIDEND_W: unsigned dividend; sampled with an accepted start.
- `div_in_divisor`  in  DIVISOR_W: unsigned divisor; sampled with an accepted start.
- `div_busy`  out  1: high while an operation is in progress.
- `div_valid`  out  1: one-cycle pulse; results are valid in that cycle and held until the next accept.
- `div_quot`  out  DIVIDEND_W: quotient.
- `div_rem`  out  DIVISOR_W: remainder.
- `div_zero`  out  1: high with `div_valid` when the divisor was 0; held with the results.

## Operation
- FSM states: IDLE and CALC.
  - IDLE → CALC when `div_start`=1 and the divisor is nonzero.
  - CALC → IDLE after DIVIDEND_W iterations.
- Accept:
  - Dividend and divisor are latched into internal registers.
  - The partial remainder register (DIVISOR_W+1 bits) clears.
  - The iteration counter loads DIVIDEND_W-1.
  - `div_zero` clears.
- Iteration (one per clock in CALC):
  - Shift `{rem, dividend}` left by 1.
  - Trial = rem − divisor.
  - If the trial is non-negative, rem = trial and the quotient bit = 1; otherwise the quotient bit = 0.
  - The quotient is built MSB first in the freed dividend LSBs.
- Arithmetic: all unsigned. The final remainder is always < divisor and fits in DIVISOR_W bits; the extra partial-remainder bit only guards the trial subtraction.
- Divide by zero (start with divisor = 0):
  - No CALC; the FSM stays in IDLE.
  - Outputs: `div_quot`=all ones, `div_rem`=0, `div_zero`=1, `div_valid` pulse.
- A start while busy is ignored: no queueing and no effect on the running operation.
- Operand inputs are don't-care except on the accept edge.
- Reset, including mid-operation:
  - FSM returns to IDLE and the counter clears.
  - `div_busy`, `div_valid`, `div_zero` = 0; `div_quot` and `div_rem` = 0.
  - A partial result is never presented.

## Timing
- Accept at rising edge k. `div_busy`=1 from after edge k through edge k+DIVIDEND_W.
- Iterations occur at edges k+1 … k+DIVIDEND_W. The final edge writes `div_quot`/`div_rem`, sets `div_valid`=1 and `div_busy`=0.
- Latency from the accept edge to the valid cycle is DIVIDEND_W clocks (18 by default).
- Divide by zero: `div_valid` follows at edge k+1, and `div_busy` never asserts.
- `div_valid` falls at the next edge.
- A start sampled at the same edge that produces `div_valid` is not accepted, because that edge is still in CALC. The earliest next accept is the following edge. Back-to-back throughput is therefore one result per DIVIDEND_W+1 clocks.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `div_pkg`: DIVIDEND_W and DIVISOR_W defaults, and the FSM state encoding constants (IDLE=0, CALC=1).
- Optional sub-module `div_step`: a combinational single restoring step, taking the partial remainder, the incoming bit and the divisor, and producing the next remainder and the quotient bit. The top level holds the FSM, counter and registers.
- Expected size: about 150–250 RTL lines.

## Test plan
- 3000/50 (= (10+40)*(25+35)): `div_valid` arrives 18 clocks after the accept, with `div_quot`=60, `div_rem`=0, `div_zero`=0.
- 1000/7 gives quot=142, rem=6. 0x3FFFF/0x1FF gives quot=513, rem=0. 5/9 gives quot=0, rem=5.
- Divisor 0, dividend 1234: `div_valid` arrives 1 clock after the accept, with quot=0x3FFFF, rem=0, `div_zero`=1, and `div_busy` never high.
- Start 1000/7, then at cycle +5 pulse start with 50/5: the first result is still 142 r 6 at +18, and the second request is ignored.
- Start at cycle +18 is ignored; start at +19 is accepted. Also run back-to-back 3000/50 and 262143/511: results 60 r 0, then 513 r 0, with valids 19 clocks apart.
- Assert `sys_rst_n`=0 at cycle +9 of an operation: all outputs go to 0 immediately (asynchronously). After release, a new 1000/7 returns 142 r 6 with correct latency.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential restoring divider.
//   - Default operand widths (18-bit dividend/quotient, 9-bit divisor/remainder).
//   - FSM state encoding constants (IDLE=0, CALC=1).
//   - cnt_width(): width of an iteration counter that must hold n-1.
package div_pkg;

   localparam int DIVIDEND_W_DEF = 18;
   localparam int DIVISOR_W_DEF  = 9;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_CALC = 1'b1;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   rem_in   [DIVISOR_W:0]   partial remainder before the step
//   bit_in                   next dividend bit shifted into the remainder
//   divisor  [DIVISOR_W-1:0] unsigned divisor
//   rem_out  [DIVISOR_W:0]   partial remainder after the step
//   quot_bit                 quotient bit produced by this step
module div_step
   import div_pkg::*;
#(
   parameter int DIVISOR_W = DIVISOR_W_DEF
) (
   input  logic [DIVISOR_W:0]   rem_in,
   input  logic                 bit_in,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   rem_out,
   output logic                 quot_bit
);

   logic [DIVISOR_W:0]   shifted;
   logic [DIVISOR_W+1:0] diff;
   logic                 unused_msb;

   // The incoming remainder is always < divisor, so its guard bit is zero
   // and falls off the shift.
   assign unused_msb = rem_in[DIVISOR_W];

   always_comb begin
      shifted  = {rem_in[DIVISOR_W-1:0], bit_in};
      // One extra bit on the trial subtraction exposes the borrow.
      diff     = {1'b0, shifted} - {2'b00, divisor};
      quot_bit = ~diff[DIVISOR_W+1];
      rem_out  = quot_bit ? diff[DIVISOR_W:0] : shifted;
   end

endmodule

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
// Ports:
//   sys_clk, sys_rst_n            clock (rising edge), async active-low reset
//   div_start                     request, sampled only while idle
//   div_in_dividend/div_in_divisor unsigned operands, sampled on accept
//   div_busy                      high while an operation is in progress
//   div_valid                     one-cycle result pulse
//   div_quot, div_rem             quotient / remainder, held after div_valid
//   div_zero                      divisor was zero (quot=all ones, rem=0)
module div_seq
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  div_start,
   input  logic [DIVIDEND_W-1:0] div_in_dividend,
   input  logic [DIVISOR_W-1:0]  div_in_divisor,
   output logic                  div_busy,
   output logic                  div_valid,
   output logic [DIVIDEND_W-1:0] div_quot,
   output logic [DIVISOR_W-1:0]  div_rem,
   output logic                  div_zero
);

   localparam int              CNT_W    = cnt_width(DIVIDEND_W);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

   logic [0:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic                  zero_pend;
   logic [DIVIDEND_W-1:0] dvd;
   logic [DIVISOR_W-1:0]  dvs;
   logic [DIVISOR_W:0]    prem;
   logic [DIVISOR_W:0]    prem_next;
   logic                  qbit;
   logic                  accept;

   // A divide-by-zero request occupies one cycle (zero_pend) before its
   // result pulse; no new request is taken during that cycle.
   assign accept   = (state == ST_IDLE) && !zero_pend && div_start;
   assign div_busy = (state == ST_CALC);

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .rem_in   (prem),
      .bit_in   (dvd[DIVIDEND_W-1]),
      .divisor  (dvs),
      .rem_out  (prem_next),
      .quot_bit (qbit)
   );

   // Control and result registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         zero_pend <= 1'b0;
         div_valid <= 1'b0;
         div_quot  <= '0;
         div_rem   <= '0;
         div_zero  <= 1'b0;
      end else begin
         div_valid <= 1'b0;
         zero_pend <= 1'b0;
         if (accept) begin
            div_zero <= 1'b0;
            if (div_in_divisor != '0) begin
               state <= ST_CALC;
               cnt   <= CNT_LOAD;
            end else begin
               zero_pend <= 1'b1;
            end
         end else if (zero_pend) begin
            div_valid <= 1'b1;
            div_quot  <= '1;
            div_rem   <= '0;
            div_zero  <= 1'b1;
         end else if (state == ST_CALC) begin
            if (cnt == '0) begin
               // Last iteration: publish the completed step directly.
               state     <= ST_IDLE;
               div_valid <= 1'b1;
               div_quot  <= {dvd[DIVIDEND_W-2:0], qbit};
               div_rem   <= prem_next[DIVISOR_W-1:0];
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end

   // Datapath: {prem, dvd} shifts left each iteration while quotient bits
   // fill the freed dividend LSBs, MSB first.
   always_ff @(posedge sys_clk) begin
      if (accept) begin
         dvd  <= div_in_dividend;
         dvs  <= div_in_divisor;
         prem <= '0;
      end else if (state == ST_CALC) begin
         dvd  <= {dvd[DIVIDEND_W-2:0], qbit};
         prem <= prem_next;
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq (18/9 defaults).
// A behavioural model predicts busy/valid/results from operand arithmetic
// and request timing; a compare process checks every cycle, and directed
// cases pin literal expectations.
module tb_div_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [17:0] dvd;
   logic [8:0]  dvs;
   logic        div_busy;
   logic        div_valid;
   logic [17:0] div_quot;
   logic [8:0]  div_rem;
   logic        div_zero;

   int n_vec;
   int n_err;

   div_seq dut (
      .sys_clk         (clk),
      .sys_rst_n       (rst_n),
      .div_start       (start),
      .div_in_dividend (dvd),
      .div_in_divisor  (dvs),
      .div_busy        (div_busy),
      .div_valid       (div_valid),
      .div_quot        (div_quot),
      .div_rem         (div_rem),
      .div_zero        (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: an operation occupies m_left edges after accept
   // (18, or 1 for a zero divisor); results come from / and %.
   int          m_left;
   logic        m_busy, m_valid, m_zero, p_zero;
   logic [17:0] m_quot, p_dvd;
   logic [8:0]  m_rem, p_dvs;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0; m_busy = 0; m_valid = 0;
         m_quot = 0; m_rem = 0; m_zero = 0;
      end else begin
         m_valid = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_valid = 1;
               m_busy  = 0;
               if (p_zero) begin
                  m_quot = 18'h3FFFF; m_rem = 0; m_zero = 1;
               end else begin
                  m_quot = p_dvd / {9'd0, p_dvs};
                  m_rem  = 9'(p_dvd % {9'd0, p_dvs});
               end
            end
         end else if (start) begin
            p_dvd  = dvd;
            p_dvs  = dvs;
            p_zero = (dvs == 0);
            m_zero = 0;
            m_left = p_zero ? 1 : 18;
            m_busy = !p_zero;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy",  32'(div_busy),  32'(m_busy));
         chk("valid", 32'(div_valid), 32'(m_valid));
         chk("quot",  32'(div_quot),  32'(m_quot));
         chk("rem",   32'(div_rem),   32'(m_rem));
         chk("zero",  32'(div_zero),  32'(m_zero));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [17:0] a, input logic [8:0] b);
      start = 1'b1; dvd = a; dvs = b;
      tick();
      start = 1'b0;
      dvd = 18'($urandom);
      dvs = 9'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!div_valid && lat < 40);
      n_vec++;
      if (!div_valid) begin
         n_err++;
         $display("FAIL valid_timeout actual=none after %0d cycles required=valid pulse", lat);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"},  32'(div_busy),  0);
      chk({nm, "_valid"}, 32'(div_valid), 0);
      chk({nm, "_quot"},  32'(div_quot),  0);
      chk({nm, "_rem"},   32'(div_rem),   0);
      chk({nm, "_zero"},  32'(div_zero),  0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          nv;
      logic [17:0] t_dvd [3];
      logic [8:0]  t_dvs [3];
      logic [17:0] t_q   [3];
      logic [8:0]  t_r   [3];

      t_dvd = '{18'd1000, 18'h3FFFF, 18'd5};
      t_dvs = '{9'd7,     9'h1FF,    9'd9};
      t_q   = '{18'd142,  18'd513,   18'd0};
      t_r   = '{9'd6,     9'd0,      9'd5};

      n_vec = 0; n_err = 0;
      rst_n = 1'b0; start = 1'b0; dvd = '0; dvs = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // (10+40)*(25+35) recovered from (10+40)
      do_start(18'd3000, 9'd50);
      wait_valid(lat);
      chk("lat_3000", 32'(lat), 18);
      chk("q_3000", 32'(div_quot), 60);
      chk("r_3000", 32'(div_rem), 0);
      chk("z_3000", 32'(div_zero), 0);
      repeat (2) tick();

      for (int i = 0; i < 3; i++) begin
         do_start(t_dvd[i], t_dvs[i]);
         wait_valid(lat);
         chk("lat_tab", 32'(lat), 18);
         chk("q_tab", 32'(div_quot), 32'(t_q[i]));
         chk("r_tab", 32'(div_rem), 32'(t_r[i]));
         tick();
      end

      // Divide by zero
      do_start(18'd1234, 9'd0);
      chk("busy_dz", 32'(div_busy), 0);
      wait_valid(lat);
      chk("lat_dz", 32'(lat), 1);
      chk("q_dz", 32'(div_quot), 32'h3FFFF);
      chk("r_dz", 32'(div_rem), 0);
      chk("z_dz", 32'(div_zero), 1);
      repeat (2) tick();

      // Start while busy is ignored
      do_start(18'd1000, 9'd7);
      repeat (4) tick();
      start = 1'b1; dvd = 18'd50; dvs = 9'd5;
      tick();
      start = 1'b0;
      wait_valid(lat);
      chk("lat_ign", 32'(lat), 13);
      chk("q_ign", 32'(div_quot), 142);
      chk("r_ign", 32'(div_rem), 6);
      nv = 0;
      repeat (22) begin
         tick();
         if (div_valid) nv++;
      end
      chk("no_second", 32'(nv), 0);

      // Start at +18 ignored, at +19 accepted; valids 19 apart
      do_start(18'd3000, 9'd50);
      repeat (17) tick();
      start = 1'b1; dvd = 18'h3FFFF; dvs = 9'h1FF;
      tick();
      chk("b2b_v1", 32'(div_valid), 1);
      chk("b2b_q1", 32'(div_quot), 60);
      tick();
      start = 1'b0;
      chk("b2b_busy", 32'(div_busy), 1);
      wait_valid(lat);
      chk("b2b_lat", 32'(lat), 18);
      chk("b2b_q2", 32'(div_quot), 513);
      chk("b2b_r2", 32'(div_rem), 0);
      repeat (2) tick();

      // Asynchronous reset mid-operation
      do_start(18'd1000, 9'd7);
      repeat (8) tick();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      do_start(18'd1000, 9'd7);
      wait_valid(lat);
      chk("rst_lat", 32'(lat), 18);
      chk("rst_q", 32'(div_quot), 142);
      chk("rst_r", 32'(div_rem), 6);
      tick();

      // Randomized traffic, including starts while busy and zero divisors
      repeat (2000) begin
         int r;
         start = ($urandom_range(0, 2) == 0);
         dvd   = 18'($urandom);
         r     = int'($urandom_range(0, 15));
         if (r == 0)      dvs = 9'd0;
         else if (r < 4)  dvs = 9'($urandom_range(1, 15));
         else             dvs = 9'($urandom);
         tick();
      end
      start = 1'b0;
      repeat (25) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
